// File: rtl/double_unit_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// double_arb_pkg
//   Shared types and helpers for double_unit_arbiter and its round-robin picker.
//   - arb_state_e  : FSM states of the arbiter (IDLE, CALC, RESP)
//   - id_width()   : width of a requester index for a given requester count
//   - double_value : the doubling datapath (result plus carry-out), gated by en
// -----------------------------------------------------------------------------
package double_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Widest operand double_value() can handle. The result occupies bits
    // [DV_MAX_W-1:0] of the return value and the carry-out sits in bit DV_MAX_W.
    localparam int DV_MAX_W = 64;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int DEFAULT_ID_W    = id_width(DEFAULT_NUM_REQ);

    // Doubles the low 'width' bits of op. Bits at or above 'width' are zero in
    // the result, so the doubling wraps modulo 2^width; the bit shifted out of
    // the top of the operand is returned as the carry in bit DV_MAX_W.
    // When en is low both the result and the carry are zero.
    function automatic logic [DV_MAX_W:0] double_value(
        input logic [DV_MAX_W-1:0] op,
        input logic                en,
        input int                  width
    );
        logic [DV_MAX_W:0] r;
        r = '0;
        if (en) begin
            for (int b = 1; b < DV_MAX_W; b++) begin
                if (b < width) begin
                    r[b] = op[b-1];
                end
            end
            for (int b = 0; b < DV_MAX_W; b++) begin
                if (b == width - 1) begin
                    r[DV_MAX_W] = op[b];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/double_unit_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches req upward starting at ptr+1,
//   wrapping modulo NUM_REQ, and reports the first asserted index.
//   Ports:
//     req   in  NUM_REQ  request vector
//     ptr   in  ID_W     index of the most recently served requester
//     valid out 1        at least one request is asserted
//     gnt   out NUM_REQ  one-hot grant (all zero when valid is low)
//     idx   out ID_W     winner index (zero when valid is low)
// -----------------------------------------------------------------------------
module rr_pick
    import double_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);

    // Candidate k is the requester visited k-th in the search order, so
    // candidate 0 is ptr+1 and candidate NUM_REQ-1 is ptr itself.
    logic [ID_W-1:0]    cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_req;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = ID_W'((int'(ptr) + 1 + gi) % NUM_REQ);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        gnt   = '0;
        // Walk from the back so the earliest candidate in search order wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                valid = 1'b1;
                idx   = cand_idx[k];
            end
        end
        if (valid) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/double_unit_arbiter.sv
// -----------------------------------------------------------------------------
// double_unit_arbiter
//   Shares one doubling datapath between NUM_REQ requesters. Requests are
//   round-robin arbitrated, the winner's operand is doubled in a dedicated
//   CALC cycle, and the result is presented on one response channel tagged
//   with the owning requester's index.
//   Ports:
//     clk         in   1             rising-edge clock
//     rst         in   1             synchronous active-high reset
//     en          in   1             datapath enable, sampled in CALC only
//     req_valid   in   NUM_REQ       per-requester valid
//     req_data    in   NUM_REQ*WIDTH per-requester operand
//     req_ready   out  NUM_REQ       per-requester accept, one-hot or zero
//     resp_valid  out  1             result available
//     resp_ready  in   1             consumer accepts the result
//     resp_data   out  WIDTH         doubled operand (mod 2^WIDTH)
//     resp_ovf    out  1             carry out of the doubling
//     resp_id     out  ID_W          requester that owns the result
//     busy        out  1             FSM is not in IDLE
// -----------------------------------------------------------------------------
module double_unit_arbiter
    import double_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [WIDTH-1:0]               resp_data,
    output logic                           resp_ovf,
    output logic [ID_W-1:0]                resp_id,
    output logic                           busy
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] ptr_q,   ptr_d;
    logic [ID_W-1:0] id_q,    id_d;
    logic [WIDTH-1:0] op_q,   op_d;
    logic [WIDTH-1:0] res_q,  res_d;
    logic            ovf_q,   ovf_d;

    logic               pick_valid;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]    pick_idx;

    logic [DV_MAX_W:0]  dbl;
    logic               dbl_unused;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .gnt   (pick_gnt),
        .idx   (pick_idx)
    );

    assign dbl        = double_value(DV_MAX_W'(op_q), en, WIDTH);
    // Bits above WIDTH are always zero for an operand of this width.
    assign dbl_unused = ^dbl[DV_MAX_W-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        op_d      = op_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        req_ready = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    // Grant is suppressed during reset so no requester sees a
                    // handshake that the reset is about to discard.
                    req_ready = rst ? '0 : pick_gnt;
                    op_d      = req_data[pick_idx];
                    id_d      = pick_idx;
                    state_d   = CALC;
                end
            end
            CALC: begin
                res_d   = dbl[WIDTH-1:0];
                ovf_d   = dbl[DV_MAX_W];
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    // The served requester becomes the search start point,
                    // so it has lowest priority next time.
                    ptr_d   = id_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            op_q    <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_data  = resp_valid ? res_q : '0;
    assign resp_ovf   = resp_valid & ovf_q;
    assign resp_id    = resp_valid ? id_q : '0;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_double_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_double_unit_arbiter
//   Self-checking bench for double_unit_arbiter with NUM_REQ=4, WIDTH=8.
//   Inputs are driven 2 time units after each rising edge and outputs are
//   sampled 1 unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_double_unit_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [N-1:0]          req_valid;
    logic [N-1:0][W-1:0]   req_data;
    logic [N-1:0]          req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [W-1:0]          resp_data;
    logic                  resp_ovf;
    logic [IW-1:0]         resp_id;
    logic                  busy;

    int n_cmp = 0;
    int n_err = 0;
    int mdl_ptr;

    double_unit_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_ovf   (resp_ovf),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    // Reference arbitration: first valid index searching upward from p+1.
    function automatic int model_pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (p + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int model_res(input int op, input bit e);
        return e ? (op * 2) % 256 : 0;
    endfunction

    function automatic bit model_ovf(input int op, input bit e);
        return e && (op >= 128);
    endfunction

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; resp_ready = 1'b1; req_valid = '1;
        for (int i = 0; i < N; i++) req_data[i] = W'($urandom_range(0, 255));
        step; step; #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({resp_valid, resp_data, resp_ovf, resp_id} !== 12'h000) begin
            n_err++; $display("FAIL reset_resp: got valid=%b data=%h ovf=%b id=%0d want all 0", resp_valid, resp_data, resp_ovf, resp_id);
        end
        rst = 1'b0; req_valid = '0; mdl_ptr = N - 1;
        step;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_single;
        req_valid = 4'b0100; req_data[2] = 8'h21; en = 1'b1; resp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        step; req_valid = '0; #1;
        n_cmp++; if ({busy, resp_valid, req_ready} !== 6'b100000) begin
            n_err++; $display("FAIL single_calc: got busy=%b valid=%b ready=%b want 1 0 0000", busy, resp_valid, req_ready);
        end
        step; #1;
        n_cmp++; if ({resp_valid, resp_data, resp_ovf, resp_id} !== {1'b1, 8'h42, 1'b0, 2'd2}) begin
            n_err++; $display("FAIL single_resp: got valid=%b data=%h ovf=%b id=%0d want 1 42 0 2", resp_valid, resp_data, resp_ovf, resp_id);
        end
        step; #1;
        n_cmp++; if ({busy, resp_valid} !== 2'b00) begin n_err++; $display("FAIL single_return: got busy=%b valid=%b want 0 0", busy, resp_valid); end
        mdl_ptr = 2;
        $display("single: id=2 op=21 data=%h", resp_data);
    endtask

    task automatic test_overflow_enable;
        logic [8:0] want [2];
        want[0] = {8'h86, 1'b1};
        want[1] = {8'h00, 1'b0};
        for (int pass = 0; pass < 2; pass++) begin
            req_valid = 4'b0001; req_data[0] = 8'hC3; en = 1'b1; resp_ready = 1'b1;
            #1;
            n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL ovf_grant%0d: got %b want 0001", pass, req_ready); end
            step; req_valid = '0; en = (pass == 0);
            step; en = ~en; #1;
            n_cmp++; if ({resp_valid, resp_data, resp_ovf} !== {1'b1, want[pass]}) begin
                n_err++; $display("FAIL ovf_en%0d: got valid=%b data=%h ovf=%b want 1 %h %b", pass, resp_valid, resp_data, resp_ovf, want[pass][8:1], want[pass][0]);
            end
            $display("ovf/en pass %0d: data=%h ovf=%b", pass, resp_data, resp_ovf);
            step;
            mdl_ptr = 0;
        end
    endtask

    task automatic test_round_robin;
        int order [5];
        order = '{0, 1, 2, 3, 0};
        rst = 1'b1; step; rst = 1'b0; mdl_ptr = N - 1;
        for (int i = 0; i < N; i++) req_data[i] = W'(16 * (i + 1) + 8);
        req_valid = '1; en = 1'b1; resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int opv;
            opv = 16 * (order[k] + 1) + 8;
            #1;
            n_cmp++; if (req_ready !== N'(1 << order[k])) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, N'(1 << order[k])); end
            step; #1;
            n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rr_calc_ready%0d: got %b want 0000", k, req_ready); end
            step; #1;
            n_cmp++; if ({resp_valid, resp_id, resp_data} !== {1'b1, IW'(order[k]), W'(model_res(opv, 1'b1))}) begin
                n_err++; $display("FAIL rr_resp%0d: got valid=%b id=%0d data=%h want 1 %0d %h", k, resp_valid, resp_id, resp_data, order[k], model_res(opv, 1'b1));
            end
            $display("round-robin %0d: id=%0d data=%h", k, resp_id, resp_data);
            step;
        end
        req_valid = '0;
        mdl_ptr = 0;
    endtask

    task automatic test_backpressure;
        int exp_id;
        int opv;
        opv = $urandom_range(0, 255);
        req_valid = 4'b1000; req_data[3] = W'(opv); en = 1'b1; resp_ready = 1'b0;
        exp_id = model_pick(4'b1000, mdl_ptr);
        #1;
        n_cmp++; if (req_ready !== N'(1 << exp_id)) begin n_err++; $display("FAIL bp_grant: got %b want %b", req_ready, N'(1 << exp_id)); end
        step; req_valid = '1; #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_calc_ready: got %b want 0000", req_ready); end
        step;
        for (int c = 0; c < 5; c++) begin
            en = $urandom_range(0, 1); #1;
            n_cmp++; if ({resp_valid, resp_id, resp_data, resp_ovf, req_ready} !== {1'b1, IW'(exp_id), W'(model_res(opv, 1'b1)), model_ovf(opv, 1'b1), 4'b0000}) begin
                n_err++; $display("FAIL bp_hold%0d: got valid=%b id=%0d data=%h ovf=%b ready=%b", c, resp_valid, resp_id, resp_data, resp_ovf, req_ready);
            end
            step;
        end
        resp_ready = 1'b1; #1;
        n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_release_valid: got %b want 1", resp_valid); end
        step; #1;
        n_cmp++; if ({busy, req_ready} !== {1'b0, N'(1 << model_pick('1, exp_id))}) begin
            n_err++; $display("FAIL bp_idle: got busy=%b ready=%b want 0 %b", busy, req_ready, N'(1 << model_pick('1, exp_id)));
        end
        req_valid = '0;
        step;
        mdl_ptr = exp_id;
        $display("backpressure: id=%0d op=%h held 5 cycles", exp_id, opv);
    endtask

    task automatic test_reset_mid;
        req_valid = 4'b0010; req_data[1] = W'($urandom_range(0, 255)); resp_ready = 1'b1; en = 1'b1;
        step;
        rst = 1'b1; req_valid = '0;
        step;
        rst = 1'b0; #1;
        n_cmp++; if ({busy, resp_valid} !== 2'b00) begin n_err++; $display("FAIL rstmid_idle: got busy=%b valid=%b want 0 0", busy, resp_valid); end
        mdl_ptr = N - 1;
        req_valid = '1; #1;
        n_cmp++; if (req_ready !== N'(1 << model_pick('1, mdl_ptr))) begin
            n_err++; $display("FAIL rstmid_grant: got %b want %b", req_ready, N'(1 << model_pick('1, mdl_ptr)));
        end
        req_valid = '0;
        step;
        $display("reset mid-op: first grant after reset=%b", N'(1 << model_pick('1, N - 1)));
    endtask

    task automatic test_random;
        logic [N-1:0] pending;
        int           pdata [N];
        pending = '0;
        for (int i = 0; i < N; i++) pdata[i] = 0;
        for (int t = 0; t < 40; t++) begin
            int exp_id;
            int hold;
            bit e_calc;
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
                    pending[i] = 1'b1;
                    pdata[i]   = $urandom_range(0, 255);
                end
                req_data[i] = W'(pdata[i]);
            end
            req_valid = pending; en = $urandom_range(0, 1); resp_ready = $urandom_range(0, 1);
            exp_id = model_pick(pending, mdl_ptr);
            #1;
            n_cmp++; if (req_ready !== ((exp_id < 0) ? 4'b0000 : N'(1 << exp_id))) begin
                n_err++; $display("FAIL rand_grant%0d: got %b want id %0d", t, req_ready, exp_id);
            end
            if (exp_id < 0) begin
                step; #1;
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rand_idle_hold%0d: got busy=%b want 0", t, busy); end
                $display("rand %0d: no request", t);
                continue;
            end
            step;
            pending[exp_id] = 1'b0;
            req_valid = pending;
            e_calc = $urandom_range(0, 1);
            en = e_calc;
            hold = $urandom_range(0, 3);
            resp_ready = 1'b0;
            #1;
            n_cmp++; if ({busy, resp_valid, req_ready} !== 6'b100000) begin
                n_err++; $display("FAIL rand_calc%0d: got busy=%b valid=%b ready=%b", t, busy, resp_valid, req_ready);
            end
            step;
            for (int c = 0; c <= hold; c++) begin
                en = $urandom_range(0, 1);
                resp_ready = (c == hold);
                #1;
                n_cmp++; if ({resp_valid, resp_id, resp_data, resp_ovf, req_ready} !==
                             {1'b1, IW'(exp_id), W'(model_res(pdata[exp_id], e_calc)), model_ovf(pdata[exp_id], e_calc), 4'b0000}) begin
                    n_err++; $display("FAIL rand_resp%0d: got valid=%b id=%0d data=%h ovf=%b ready=%b want id=%0d data=%h ovf=%b",
                                      t, resp_valid, resp_id, resp_data, resp_ovf, req_ready,
                                      exp_id, model_res(pdata[exp_id], e_calc), model_ovf(pdata[exp_id], e_calc));
                end
                step;
            end
            mdl_ptr = exp_id;
            $display("rand %0d: id=%0d op=%h en=%0d hold=%0d", t, exp_id, pdata[exp_id], e_calc, hold);
        end
        req_valid = '0;
        step;
    endtask

    initial begin
        test_reset;
        test_single;
        test_overflow_enable;
        test_round_robin;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
